// File: rtl/alarm_qual_if.sv
// alarm_qual_if: raw sample strobe/data toward alarm_qual and the qualified alarm flags back
interface alarm_qual_if;
    logic        vld;
    logic [11:0] batt;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        batt_low;
    logic        too_fast;
    modport master(output vld, batt, lft_spd, rght_spd, input batt_low, too_fast);
    modport slave(input vld, batt, lft_spd, rght_spd, output batt_low, too_fast);
endinterface

// File: rtl/alarm_qual.sv
// alarm_qual: threshold/hysteresis/persistence qualifier for batt_low and too_fast; TOO_FAST_LATCH_EN latches too_fast until reset
module alarm_qual #(
    parameter logic [11:0] BATT_TH   = 12'h800,
    parameter logic [11:0] BATT_HYST = 12'h040,
    parameter logic [11:0] SPD_TH    = 12'd1536,
    parameter logic [11:0] SPD_HYST  = 12'd128,
    parameter int unsigned PERSIST   = 4
) (
    input logic        clk,
    input logic        rst_n,
    alarm_qual_if.slave bus
);
    localparam logic [12:0] BREC  = {1'b0, BATT_TH} + {1'b0, BATT_HYST};
    localparam logic [11:0] SREL  = SPD_HYST > SPD_TH ? 12'd0 : SPD_TH - SPD_HYST;
    localparam logic [3:0]  PLAST = 4'(PERSIST - 1);
    localparam bit          P1    = PERSIST == 1;

    typedef enum logic [1:0] {OK, LOW_PEND, LOW, REC_PEND} bstate_t;
    typedef enum logic [1:0] {NORM, FAST, REL_PEND} sstate_t;

    bstate_t     bst;
    sstate_t     sst;
    logic [3:0]  bcnt, scnt;
    logic [11:0] la, ra;
    logic        lo, hi, fast, slow;

    // -2048 has no positive twin in 12 bits, so it clamps to 2047
    function automatic logic [11:0] sat_abs(input logic [11:0] x);
        return x == 12'h800 ? 12'h7ff : (x[11] ? -x : x);
    endfunction

    assign la   = sat_abs(bus.lft_spd);
    assign ra   = sat_abs(bus.rght_spd);
    assign lo   = bus.batt < BATT_TH;
    assign hi   = {1'b0, bus.batt} >= BREC;
    assign fast = la > SPD_TH || ra > SPD_TH;
    assign slow = la <= SREL && ra <= SREL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bst      <= OK;
            bcnt     <= '0;
            bus.batt_low <= 1'b0;
        end else begin
            case (bst)
                OK: if (bus.vld && lo) begin
                    bst          <= P1 ? LOW : LOW_PEND;
                    bcnt         <= P1 ? 4'd0 : 4'd1;
                    bus.batt_low <= P1;
                end
                LOW_PEND: if (bus.vld) begin
                    if (!lo) begin
                        bst  <= OK;
                        bcnt <= '0;
                    end else if (bcnt == PLAST) begin
                        bst          <= LOW;
                        bcnt         <= '0;
                        bus.batt_low <= 1'b1;
                    end else bcnt <= bcnt + 4'd1;
                end
                LOW: if (bus.vld && hi) begin
                    bst          <= P1 ? OK : REC_PEND;
                    bcnt         <= P1 ? 4'd0 : 4'd1;
                    bus.batt_low <= !P1;
                end
                REC_PEND: if (bus.vld) begin
                    if (!hi) begin
                        bst  <= LOW;
                        bcnt <= '0;
                    end else if (bcnt == PLAST) begin
                        bst          <= OK;
                        bcnt         <= '0;
                        bus.batt_low <= 1'b0;
                    end else bcnt <= bcnt + 4'd1;
                end
                default: begin
                    bst          <= OK;
                    bcnt         <= '0;
                    bus.batt_low <= 1'b0;
                end
            endcase
        end
    end

    // speed trips on one sample but releases only after PERSIST slow samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sst          <= NORM;
            scnt         <= '0;
            bus.too_fast <= 1'b0;
        end else begin
            case (sst)
                NORM: if (bus.vld && fast) begin
                    sst          <= FAST;
                    bus.too_fast <= 1'b1;
                end
                FAST: begin
`ifdef TOO_FAST_LATCH_EN
                    scnt <= '0;
`else
                    if (bus.vld && slow) begin
                        sst          <= P1 ? NORM : REL_PEND;
                        scnt         <= P1 ? 4'd0 : 4'd1;
                        bus.too_fast <= !P1;
                    end
`endif
                end
                REL_PEND: if (bus.vld) begin
                    if (fast) begin
                        sst  <= FAST;
                        scnt <= '0;
                    end else if (!slow) scnt <= '0;
                    else if (scnt == PLAST) begin
                        sst          <= NORM;
                        scnt         <= '0;
                        bus.too_fast <= 1'b0;
                    end else scnt <= scnt + 4'd1;
                end
                default: begin
                    sst          <= NORM;
                    scnt         <= '0;
                    bus.too_fast <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_qual.sv
// tb_alarm_qual: directed plus random samples checked against a counting model of the alarm rules
module tb_alarm_qual;
    localparam int P = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   m_low, m_fast;
    int   bc, sc;

    alarm_qual_if bus();
    alarm_qual dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int sabs(input logic [11:0] x);
        int v;
        v = $signed(x);
        return v == -2048 ? 2047 : (v < 0 ? -v : v);
    endfunction

    task automatic model_reset();
        m_low = 0; m_fast = 0; bc = 0; sc = 0;
    endtask

    task automatic model_update(input logic [11:0] b, input logic [11:0] l, input logic [11:0] r);
        int a1, a2;
        bit fast, slow, lo, hi;
        a1 = sabs(l); a2 = sabs(r);
        fast = a1 > 1536 || a2 > 1536;
        slow = a1 <= 1408 && a2 <= 1408;
        lo = int'(b) < 2048;
        hi = int'(b) >= 2112;
        bc = (m_low ? hi : lo) ? bc + 1 : 0;
        if (bc == P) begin m_low = !m_low; bc = 0; end
        if (!m_fast) begin
            if (fast) m_fast = 1;
            sc = 0;
        end else begin
`ifdef TOO_FAST_LATCH_EN
            sc = 0;
`else
            sc = slow ? sc + 1 : 0;
            if (sc == P) begin m_fast = 0; sc = 0; end
`endif
        end
    endtask

    task automatic chk(input string tag);
        checks++;
        assert (bus.batt_low === m_low) else begin
            errors++;
            $error("FAIL %s batt_low got=%0b exp=%0b", tag, bus.batt_low, m_low);
        end
        checks++;
        assert (bus.too_fast === m_fast) else begin
            errors++;
            $error("FAIL %s too_fast got=%0b exp=%0b", tag, bus.too_fast, m_fast);
        end
    endtask

    task automatic step(input bit v, input logic [11:0] b, input logic [11:0] l, input logic [11:0] r, input string tag);
        @(negedge clk);
        bus.vld = v; bus.batt = b; bus.lft_spd = l; bus.rght_spd = r;
        @(posedge clk);
        if (v && rst_n) model_update(b, l, r);
        #1 bus.vld = 1'b0;
        chk(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk(tag);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        logic [11:0] b, l, r;
        int mode, mag;
        bus.vld = 0; bus.batt = 12'hfff; bus.lft_spd = 0; bus.rght_spd = 0;
        model_reset();
        #3 chk("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1, 12'h7ff, 0, 0, "lo_x3");
        step(1, 12'h900, 0, 0, "lo_break");
        for (int i = 0; i < 4; i++) step(1, 12'h7ff, 0, 0, "lo_x4");
        checks++;
        assert (bus.batt_low === 1'b1) else begin
            errors++;
            $error("FAIL lo_set batt_low got=%0b exp=1", bus.batt_low);
        end
        for (int i = 0; i < 10; i++) step(1, 12'h820, 0, 0, "hyst_band");
        step(1, 12'h840, 0, 0, "rec1");
        step(1, 12'h840, 0, 0, "rec2");
        step(1, 12'h83f, 0, 0, "rec_break");
        for (int i = 0; i < 4; i++) step(1, 12'h840, 0, 0, "rec_x4");
        checks++;
        assert (bus.batt_low === 1'b0) else begin
            errors++;
            $error("FAIL rec_clear batt_low got=%0b exp=0", bus.batt_low);
        end

        step(1, 12'h900, 12'd1537, 0, "spd_trip");
        checks++;
        assert (bus.too_fast === 1'b1) else begin
            errors++;
            $error("FAIL spd_trip_now too_fast got=%0b exp=1", bus.too_fast);
        end
        for (int i = 0; i < 4; i++) step(1, 12'h900, 12'd1408, 12'd1408, "spd_rel");
        step(1, 12'h900, 12'd1537, 0, "spd_retrip");
        for (int i = 0; i < 8; i++) step(1, 12'h900, 12'd1500, 12'd1500, "spd_band");
        for (int i = 0; i < 4; i++) step(1, 12'h900, 12'd1000, 12'd1000, "spd_rel2");
        step(1, 12'h900, 0, 12'h800, "spd_neg2048");
        for (int i = 0; i < 100; i++) step(0, 12'h000, 12'h800, 12'h800, "vld_low");

        for (int i = 0; i < 4; i++) step(1, 12'h900, 0, 0, "pre_rst");
        for (int i = 0; i < 3; i++) step(1, 12'h100, 12'd1600, 0, "pend3");
        async_reset("async_rst");
        for (int i = 0; i < 3; i++) step(1, 12'h100, 0, 0, "post_rst_lo");

        for (int i = 0; i < 800; i++) begin
            mode = $urandom_range(0, 9);
            case ($urandom_range(0, 4))
                0: b = 12'h7ff;
                1: b = 12'h83f;
                2: b = 12'h840;
                3: b = 12'h800;
                default: b = 12'($urandom);
            endcase
            mag = mode < 6 ? $urandom_range(0, 1408) : mode < 8 ? $urandom_range(1409, 1536) : $urandom_range(1537, 2047);
            l = 12'($urandom_range(0, 1) ? -mag : mag);
            r = mode == 9 && $urandom_range(0, 3) == 0 ? 12'h800 : 12'($urandom_range(0, 1) ? -mag / 2 : mag / 2);
            if ($urandom_range(0, 1)) begin l ^= r; r ^= l; l ^= r; end
            step($urandom_range(0, 3) != 0, b, l, r, "random");
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
